hop_chain_probe: RTL and testbench
==================================

// Module: hop_chain_probe
// PURPOSE
//  Parametrised N-stage register chain (WIDTH x DEPTH) with per-stage synchronous clears that emulate
//  secondary reset domains. Includes a latency probe that injects a tag token and measures clock edges
//  to the chain output. Used as a configurable micro-benchmark for hop-count and reset-path timing studies.
// PARAMETERS
//  WIDTH    1    data bits per stage
//  DEPTH    4    number of stages (>=1)
//  CNT_W    8    probe counter / latency width
//  TIMEOUT  200  probe abort count (1 .. 2**CNT_W-1)
// PORTS
//  clock0       in   1       clock, all logic rising-edge
//  rst1         in   1       reset, asynchronous, active-high; clears all state
//  din          in   WIDTH   chain input data
//  din_vld      in   1       chain input valid
//  stage_clr    in   DEPTH   per-stage sync clear, bit k clears stage k
//  par_inj      in   1       invert stage-0 parity (effective only with HOP_PARITY_EN)
//  probe_start  in   1       request latency measurement
//  dout         out  WIDTH   last-stage data
//  dout_vld     out  1       last-stage valid
//  probe_busy   out  1       probe in WAIT
//  probe_done   out  1       1-cycle pulse, measurement finished
//  probe_lat    out  CNT_W   measured latency, held until next probe_done
//  probe_tmo    out  1       1-cycle pulse with probe_done on timeout
//  par_err      out  1       sticky parity error (0 without HOP_PARITY_EN)
// BEHAVIOUR
//  - rst1: all stages (data/vld/tag/parity) = 0, FSM IDLE, cnt = 0, all outputs 0.
//  - Shift each edge: stage0 <= {din, din_vld, tag_in}; stage k <= stage k-1.
//    Input-to-dout latency = DEPTH edges.
//  - stage_clr[k] high at edge: stage k <= 0 (data, vld, tag, parity). Clear beats shift-in;
//    stage k+1 still takes the old stage k value on that edge.
//  - FSM IDLE/WAIT/DONE.
//    - IDLE & probe_start: tag_in = 1 for that edge, cnt <= 1, go WAIT.
//    - probe_start outside IDLE is ignored.
//  - WAIT, each edge:
//    - if tag[DEPTH-1]: probe_lat <= cnt, go DONE.
//    - else if cnt == TIMEOUT: probe_lat <= all-ones, tmo flag, go DONE.
//    - else cnt <= cnt+1 (saturating at 2**CNT_W-1).
//  - DONE: probe_done = 1 (plus probe_tmo if timed out) for exactly one cycle, then IDLE.
//    probe_busy = 1 only in WAIT.
//  - No clears: probe_lat == DEPTH. DEPTH == 1 gives probe_lat == 1.
//  - Tag cleared in flight (incl. stage_clr[0] on the injection edge) -> timeout path.
//  - Only one tag is ever in the chain: injection only from IDLE.
//  - rst1 mid-probe: immediate abort, no probe_done, probe_lat = 0.
// CONFIGURATION
//  - HOP_PARITY_EN defined:
//    - Each stage carries a parity bit = ^din ^ par_inj, computed at stage 0.
//    - At the last stage, if dout_vld & (^dout != parity): par_err <= 1 next edge, sticky until rst1.
//    - A cleared stage is consistent (data 0, parity 0).
//  - HOP_PARITY_EN undefined: no parity storage; par_err tied 0; par_inj ignored.
// STRUCTURE
//  - Package hop_pkg: probe_state_t enum {IDLE, WAIT, DONE}; localparam CNT_MAX = 2**CNT_W-1.
//  - Sub-module hop_stage: one register stage {data, vld, tag[, parity]} with async rst1 and sync clr,
//    instantiated DEPTH times via generate.
//  - Top holds the FSM, counter and parity checker.
// TESTING
//  1. DEPTH=4: din=1/din_vld=1 one cycle at edge 5 -> dout=1, dout_vld=1 after edge 8, for exactly 1 cycle.
//  2. Probe, no clears, DEPTH=4 -> probe_busy 4 cycles, probe_done pulse, probe_lat=4, probe_tmo=0.
//  3. Probe, stage_clr[2]=1 while tag in stage 2 -> at cnt=200: probe_done & probe_tmo, probe_lat=8'hFF.
//  4. probe_start held high 20 cycles -> back-to-back probes; each probe_lat=4; no start accepted in WAIT.
//  5. rst1 pulsed at cnt=2 -> all outputs 0 asynchronously, no probe_done; next probe gives probe_lat=4.
//  6. HOP_PARITY_EN, WIDTH=8, par_inj=1 with din_vld=1 -> par_err=1 one edge after dout_vld, stays 1 until rst1.
//     Without the macro: par_err remains 0.

Source files
------------

// File: rtl/hop_pkg.sv
// Shared types for the hop-count chain: probe FSM states and per-stage control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a. HOP_PARITY_EN adds a parity bit to the stage control word.
package hop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } probe_state_t;

    localparam int CNT_W_DEF = 8;
    localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

    // Side-band bits that travel with each data word down the chain
    typedef struct packed {
        logic vld;
        logic tag;
`ifdef HOP_PARITY_EN
        logic par;
`endif
    } stage_ctl_t;

endpackage

// File: rtl/hop_stage.sv
// One register hop {data, ctl} with async reset and a synchronous local clear.
// Latency: 1 clock0 edge.
// Backpressure: none; the stage captures its input every edge unless cleared.
module hop_stage
    import hop_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_dat,
    input  stage_ctl_t       d_ctl,
    output logic [WIDTH-1:0] q_dat,
    output stage_ctl_t       q_ctl
);

    // Capture the previous hop; a local clear wins over the shift-in and zeroes parity too
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            q_dat <= '0;
            q_ctl <= '0;
        end else if (clr) begin
            q_dat <= '0;
            q_ctl <= '0;
        end else begin
            q_dat <= d_dat;
            q_ctl <= d_ctl;
        end
    end

endmodule

// File: rtl/hop_chain_probe.sv
// DEPTH-hop register chain with per-hop clears and a tag-based latency probe (optional HOP_PARITY_EN).
// Latency: din to dout is DEPTH edges; probe result appears one edge after the tag leaves the chain.
// Backpressure: none; probe_start is only accepted in IDLE, ignored otherwise.
module hop_chain_probe
    import hop_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 200
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic [DEPTH-1:0] stage_clr,
    input  logic             par_inj,
    input  logic             probe_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             probe_busy,
    output logic             probe_done,
    output logic [CNT_W-1:0] probe_lat,
    output logic             probe_tmo,
    output logic             par_err
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    probe_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tmo_flag;
    logic             tag_in;
    stage_ctl_t       ctl_in;
    logic [WIDTH-1:0] sdat [DEPTH];
    stage_ctl_t       sctl [DEPTH];

    // Build the stage-0 control word from the input valid, the probe tag and optional parity
    always_comb begin
        ctl_in     = '0;
        ctl_in.vld = din_vld;
        ctl_in.tag = tag_in;
`ifdef HOP_PARITY_EN
        ctl_in.par = (^din) ^ par_inj;
`endif
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            hop_stage #(.WIDTH(WIDTH)) u_stage (
                .clock0 (clock0),
                .rst1   (rst1),
                .clr    (stage_clr[k]),
                .d_dat  (din),
                .d_ctl  (ctl_in),
                .q_dat  (sdat[k]),
                .q_ctl  (sctl[k])
            );
        end else begin : g_body
            hop_stage #(.WIDTH(WIDTH)) u_stage (
                .clock0 (clock0),
                .rst1   (rst1),
                .clr    (stage_clr[k]),
                .d_dat  (sdat[k-1]),
                .d_ctl  (sctl[k-1]),
                .q_dat  (sdat[k]),
                .q_ctl  (sctl[k])
            );
        end
    end

    assign dout     = sdat[DEPTH-1];
    assign dout_vld = sctl[DEPTH-1].vld;

    // Probe state register
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) state <= IDLE;
        else      state <= state_nxt;
    end

    // Probe next-state: arrival of the tag or the timeout ends the wait
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (probe_start) state_nxt = WAIT;
            WAIT:    if (sctl[DEPTH-1].tag || (cnt == TMO_CNT)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Probe outputs; the tag is injected only on the accepting edge, so one tag at most is in flight
    always_comb begin
        tag_in     = (state == IDLE) && probe_start;
        probe_busy = (state == WAIT);
        probe_done = (state == DONE);
        probe_tmo  = (state == DONE) && tmo_flag;
    end

    // Edge counter and result capture; the counter saturates rather than wrapping
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            cnt       <= '0;
            probe_lat <= '0;
            tmo_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (probe_start) begin
                        cnt      <= CNT_W'(1);
                        tmo_flag <= 1'b0;
                    end
                end
                WAIT: begin
                    if (sctl[DEPTH-1].tag) begin
                        probe_lat <= cnt;
                    end else if (cnt == TMO_CNT) begin
                        probe_lat <= CNT_SAT;
                        tmo_flag  <= 1'b1;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HOP_PARITY_EN
    // Sticky parity check on valid words leaving the last hop
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            par_err <= 1'b0;
        end else if (sctl[DEPTH-1].vld && ((^sdat[DEPTH-1]) != sctl[DEPTH-1].par)) begin
            par_err <= 1'b1;
        end
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_hop_chain_probe.sv
// Directed bench for hop_chain_probe with scoreboards for chain data and probe results.
// Latency: n/a.
// Backpressure: n/a.
module tb_hop_chain_probe;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 200;
`ifdef HOP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clock0 = 1'b0;
    logic             rst1;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [DEPTH-1:0] stage_clr;
    logic             par_inj;
    logic             probe_start;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             probe_busy;
    logic             probe_done;
    logic [CNT_W-1:0] probe_lat;
    logic             probe_tmo;
    logic             par_err;

    typedef struct {
        logic [CNT_W-1:0] lat;
        logic             tmo;
    } probe_exp_t;

    probe_exp_t       pq [$];
    logic [WIDTH-1:0] dq [$];
    probe_exp_t       pe;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ec;
    int n;

    hop_chain_probe #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock0      (clock0),
        .rst1        (rst1),
        .din         (din),
        .din_vld     (din_vld),
        .stage_clr   (stage_clr),
        .par_inj     (par_inj),
        .probe_start (probe_start),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .probe_busy  (probe_busy),
        .probe_done  (probe_done),
        .probe_lat   (probe_lat),
        .probe_tmo   (probe_tmo),
        .par_err     (par_err)
    );

    always #5 clock0 = ~clock0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
        cyc++;
    endtask

    task automatic push_probe(input logic [CNT_W-1:0] lat, input logic tmo);
        probe_exp_t e;
        e.lat = lat;
        e.tmo = tmo;
        pq.push_back(e);
    endtask

    // Scoreboard side: compare every chain output word and every probe result as it appears
    always @(negedge clock0) begin
        if (!rst1 && dout_vld) begin
            if (dq.size() == 0) chk("dout_vld_unexpected", dout_vld, 0);
            else                chk("dout_data", dout, dq.pop_front());
        end
        if (!rst1 && probe_done) begin
            if (pq.size() == 0) begin
                chk("probe_done_unexpected", probe_done, 0);
            end else begin
                pe = pq.pop_front();
                chk("probe_lat", probe_lat, pe.lat);
                chk("probe_tmo", probe_tmo, pe.tmo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b1; din = '0; din_vld = 1'b0; stage_clr = '0; par_inj = 1'b0; probe_start = 1'b0;
        repeat (3) tick();
        chk("rst_dout",       dout, 0);
        chk("rst_dout_vld",   dout_vld, 0);
        chk("rst_probe_busy", probe_busy, 0);
        chk("rst_probe_done", probe_done, 0);
        chk("rst_probe_lat",  probe_lat, 0);
        chk("rst_probe_tmo",  probe_tmo, 0);
        chk("rst_par_err",    par_err, 0);
        rst1 = 1'b0;
        tick();

        // Single word through the chain: valid at the output for exactly one cycle, DEPTH edges later
        din = 8'h01; din_vld = 1'b1; dq.push_back(8'h01);
        tick();
        din = '0; din_vld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t1_dout_vld", dout_vld, k == 3);
        end
        chk("t1_par_err", par_err, 0);

        // Clean probe: busy for DEPTH cycles, then one done pulse with latency DEPTH
        probe_start = 1'b1; push_probe(CNT_W'(DEPTH), 1'b0);
        tick();
        probe_start = 1'b0;
        chk("t2_busy_k0", probe_busy, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t2_busy", probe_busy, k <= 3);
            chk("t2_done", probe_done, k == 4);
        end
        chk("t2_lat_held", probe_lat, DEPTH);

        // Clear stage 2 on the edge that would load the tag into it: the tag is lost -> timeout
        probe_start = 1'b1; push_probe(8'hFF, 1'b1);
        tick();
        ec = cyc;
        probe_start = 1'b0;
        tick();
        stage_clr = 4'b0100;
        tick();
        stage_clr = '0;
        n = 0;
        while (!probe_done && n < 400) begin
            tick();
            n++;
        end
        chk("t3_done_seen", probe_done, 1);
        chk("t3_tmo_edge",  cyc - ec, TIMEOUT);
        tick();
        chk("t3_done_pulse", probe_done, 0);
        chk("t3_tmo_pulse",  probe_tmo, 0);

        // probe_start held: accepted every 6 edges (accept, 3 more WAIT, DONE, IDLE) -> 4 probes in 20 edges
        repeat (4) push_probe(CNT_W'(DEPTH), 1'b0);
        probe_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (probe_busy) chk("t4_no_done_in_wait", probe_done, 0);
        end
        probe_start = 1'b0;
        repeat (10) tick();
        chk("t4_pending", pq.size(), 0);

        // Asynchronous reset mid-probe: everything drops without an edge and no done appears
        probe_start = 1'b1; push_probe(CNT_W'(DEPTH), 1'b0);
        tick();
        probe_start = 1'b0;
        tick();
        chk("t5_busy_before", probe_busy, 1);
        rst1 = 1'b1;
        pq.delete();
        #1;
        chk("t5_busy",     probe_busy, 0);
        chk("t5_done",     probe_done, 0);
        chk("t5_lat",      probe_lat, 0);
        chk("t5_tmo",      probe_tmo, 0);
        chk("t5_dout_vld", dout_vld, 0);
        repeat (2) tick();
        rst1 = 1'b0;
        tick();
        probe_start = 1'b1; push_probe(CNT_W'(DEPTH), 1'b0);
        tick();
        probe_start = 1'b0;
        repeat (8) tick();
        chk("t5_pending", pq.size(), 0);

        // Injected parity error: flags one edge after the word reaches the output, then stays set
        din = 8'hA5; din_vld = 1'b1; par_inj = 1'b1; dq.push_back(8'hA5);
        tick();
        din = 8'h3C; par_inj = 1'b0; dq.push_back(8'h3C);
        tick();
        din = '0; din_vld = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("t6_par_err", par_err, PAR && (k >= 4));
        end
        rst1 = 1'b1;
        #1;
        chk("t6_par_err_rst", par_err, 0);
        tick();
        rst1 = 1'b0;
        tick();

        chk("end_probe_pending", pq.size(), 0);
        chk("end_data_pending",  dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
